// File: rtl/dm_pkg.sv
// dm_pkg: access-size encodings and byte-enable helper for the data memory stage.
package dm_pkg;

    localparam logic [1:0] DM_WORD = 2'b00;
    localparam logic [1:0] DM_HALF = 2'b01;
    localparam logic [1:0] DM_BYTE = 2'b10;
    localparam logic [1:0] DM_ILL  = 2'b11;

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        return size == DM_WORD ? 4'b1111 :
               size == DM_HALF ? 4'b0011 << off :
               size == DM_BYTE ? 4'b0001 << off : 4'b0000;
    endfunction

endpackage

// File: rtl/dm_load_ext.sv
// dm_load_ext: lane select plus sign/zero extension of a stored word.
module dm_load_ext
    import dm_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        uns,
    output logic [31:0] rd
);

    logic [15:0] h;
    logic [7:0]  b;

    assign h  = word[{off[1], 4'b0000} +: 16];
    assign b  = word[{off, 3'b000} +: 8];
    assign rd = size == DM_WORD ? word :
                size == DM_HALF ? {{16{~uns & h[15]}}, h} :
                size == DM_BYTE ? {{24{~uns & b[7]}}, b} : 32'h0;

endmodule

// File: rtl/dm.sv
// dm: byte-addressed data memory with sub-word stores, extended loads and address-error flags.
module dm
    import dm_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] DM_Addr,
    input  logic [31:0] DM_WD,
    input  logic        DM_WE,
    input  logic        DM_RE,
    input  logic [1:0]  DM_Size,
    input  logic        DM_Unsigned,
    output logic [31:0] DM_RD,
    output logic        DM_AdEL,
    output logic        DM_AdES
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic [3:0]            be;
    logic [31:0]           wdata;
    logic [31:0]           ext;
    logic                  bad;

    assign idx = DM_Addr[ADDR_WIDTH+1:2];
    assign be  = byte_en(DM_Size, DM_Addr[1:0]);
    // Any set bit above the index is out of range; never truncated into a legal word.
    assign bad = |DM_Addr[31:ADDR_WIDTH+2] | (DM_Size == DM_ILL) |
                 (DM_Size == DM_WORD && |DM_Addr[1:0]) |
                 (DM_Size == DM_HALF && DM_Addr[0]);

    assign DM_AdEL = DM_RE & bad;
    assign DM_AdES = DM_WE & bad;

    // Replicate sub-word data across lanes so byte enables alone pick the target.
    assign wdata = DM_Size == DM_WORD ? DM_WD :
                   DM_Size == DM_HALF ? {2{DM_WD[15:0]}} : {4{DM_WD[7:0]}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
        end else if (DM_WE && !bad) begin
            for (int j = 0; j < 4; j++)
                if (be[j]) mem[idx][8*j +: 8] <= wdata[8*j +: 8];
        end
    end

    dm_load_ext u_ext (
        .word (mem[idx]),
        .size (DM_Size),
        .off  (DM_Addr[1:0]),
        .uns  (DM_Unsigned),
        .rd   (ext)
    );

    assign DM_RD = (DM_RE && !bad) ? ext : 32'h0;

endmodule

// File: tb/tb_dm.sv
// tb_dm: byte-array reference model with per-cycle comparison plus directed literal checks.
module tb_dm;

    logic        clk = 0;
    logic        rst_n = 0;
    logic [31:0] DM_Addr = 0;
    logic [31:0] DM_WD = 0;
    logic        DM_WE = 0;
    logic        DM_RE = 0;
    logic [1:0]  DM_Size = 0;
    logic        DM_Unsigned = 0;
    logic [31:0] DM_RD;
    logic        DM_AdEL;
    logic        DM_AdES;

    int total = 0;
    int passed = 0;
    logic [7:0] mb [4096];

    dm dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .DM_Addr     (DM_Addr),
        .DM_WD       (DM_WD),
        .DM_WE       (DM_WE),
        .DM_RE       (DM_RE),
        .DM_Size     (DM_Size),
        .DM_Unsigned (DM_Unsigned),
        .DM_RD       (DM_RD),
        .DM_AdEL     (DM_AdEL),
        .DM_AdES     (DM_AdES)
    );

    always #5 clk = ~clk;

    function automatic int nbytes(input logic [1:0] size);
        return size == 2'b00 ? 4 : size == 2'b01 ? 2 : 1;
    endfunction

    function automatic logic model_bad(input logic [31:0] addr, input logic [1:0] size);
        return addr >= 32'd4096 || size == 2'b11 ||
               (size == 2'b00 && addr % 4 != 0) || (size == 2'b01 && addr % 2 != 0);
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] addr, input logic [1:0] size,
                                             input logic uns, input logic re);
        logic [31:0] v;
        int n;
        if (!re || model_bad(addr, size)) return 32'h0;
        n = nbytes(size);
        v = 0;
        for (int k = 0; k < n; k++) v = v | (32'(mb[int'(addr) + k]) << (8 * k));
        if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    always @(negedge rst_n) for (int i = 0; i < 4096; i++) mb[i] = 8'h0;

    always @(posedge clk)
        if (rst_n && DM_WE && !model_bad(DM_Addr, DM_Size))
            for (int k = 0; k < nbytes(DM_Size); k++)
                mb[int'(DM_Addr) + k] = DM_WD[8*k +: 8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    always @(negedge clk) begin
        chk("model_rd", DM_RD, model_rd(DM_Addr, DM_Size, DM_Unsigned, DM_RE));
        chk("model_adel", 32'(DM_AdEL), 32'(DM_RE & model_bad(DM_Addr, DM_Size)));
        chk("model_ades", 32'(DM_AdES), 32'(DM_WE & model_bad(DM_Addr, DM_Size)));
    end

    task automatic drive(input logic we, input logic re, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wd);
        @(posedge clk);
        #1;
        DM_WE = we; DM_RE = re; DM_Size = size; DM_Unsigned = uns; DM_Addr = addr; DM_WD = wd;
    endtask

    task automatic look(input string name, input logic [31:0] exp);
        @(negedge clk);
        chk(name, DM_RD, exp);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        drive(0, 1, 2'b00, 0, 32'h10, 0);
        look("reset_rd", 32'h0);
        chk("reset_flags", {DM_AdEL, DM_AdES}, 32'h0);
        drive(1, 0, 2'b00, 0, 32'h10, 32'h8765_4321);
        drive(0, 1, 2'b10, 0, 32'h11, 0);
        look("lb_11", 32'h0000_0043);
        drive(0, 1, 2'b10, 1, 32'h13, 0);
        look("lbu_13", 32'h0000_0087);
        drive(0, 1, 2'b10, 0, 32'h13, 0);
        look("lb_13", 32'hFFFF_FF87);
        drive(0, 1, 2'b01, 0, 32'h12, 0);
        look("lh_12", 32'hFFFF_8765);
        drive(1, 0, 2'b10, 0, 32'h12, 32'h0000_00AA);
        drive(0, 1, 2'b00, 0, 32'h10, 0);
        look("sb_merge", 32'h87AA_4321);
        drive(1, 0, 2'b01, 0, 32'h10, 32'h0000_BEEF);
        drive(0, 1, 2'b00, 0, 32'h10, 0);
        look("sh_merge", 32'h87AA_BEEF);
        drive(1, 0, 2'b00, 0, 32'h20, 32'h1122_3344);
        drive(1, 0, 2'b00, 0, 32'h22, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("mis_ades", 32'(DM_AdES), 32'h1);
        drive(0, 1, 2'b00, 0, 32'h20, 0);
        look("mis_unchanged", 32'h1122_3344);
        drive(0, 1, 2'b01, 0, 32'h21, 0);
        look("lh_mis_rd", 32'h0);
        chk("lh_mis_adel", 32'(DM_AdEL), 32'h1);
        drive(0, 1, 2'b11, 0, 32'h10, 0);
        @(negedge clk);
        chk("ill_adel", 32'(DM_AdEL), 32'h1);
        drive(1, 0, 2'b00, 0, 32'h0, 32'h55AA_55AA);
        drive(1, 0, 2'b00, 0, 32'hFFC, 32'h1234_5678);
        drive(0, 1, 2'b00, 0, 32'hFFC, 0);
        look("last_word", 32'h1234_5678);
        chk("last_word_flag", 32'(DM_AdEL), 32'h0);
        drive(1, 0, 2'b00, 0, 32'h1000, 32'hCAFE_F00D);
        @(negedge clk);
        chk("range_ades", 32'(DM_AdES), 32'h1);
        drive(0, 1, 2'b00, 0, 32'h0, 0);
        look("no_wrap", 32'h55AA_55AA);
        for (int a = 'h10; a <= 'h1C; a += 4) drive(1, 0, 2'b00, 0, a, 32'hA000_0000 + a);
        drive(0, 1, 2'b00, 0, 32'h1C, 0);
        look("fill_1c", 32'hA000_001C);
        #2 rst_n = 0;
        #1 chk("async_clear", DM_RD, 32'h0);
        DM_WE = 1; DM_WD = 32'hFFFF_FFFF; DM_Addr = 32'h10;
        @(posedge clk);
        #1 chk("reset_store_rd", DM_RD, 32'h0);
        DM_WE = 0;
        rst_n = 1;
        drive(0, 1, 2'b00, 0, 32'h10, 0);
        look("reset_store_drop", 32'h0);
        for (int i = 0; i < 400; i++) begin
            int p;
            logic [31:0] a;
            p = $urandom_range(0, 19);
            a = p < 14 ? 32'($urandom_range(0, 63)) :
                p < 17 ? 32'(4096 - $urandom_range(1, 16)) :
                p < 19 ? 32'(4096 + $urandom_range(0, 7)) : $urandom;
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), a, $urandom);
        end
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dm.md
# dm

Data memory stage of the single-cycle MIPS datapath, directly downstream of the ALU. Takes the ALU result as a byte address and the `rt` register value as store data. Performs word, halfword and byte stores on the clock edge. Returns sign- or zero-extended load data combinationally so the write-back mux sees it in the same cycle. Flags misaligned or out-of-range accesses instead of corrupting memory.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: word-index width; capacity is 2^ADDR_WIDTH words (4 KiB default).

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `DM_Addr`  in  32  byte address (ALU result).
- `DM_WD`  in  32  store data; the low byte/halfword is used for sub-word stores.
- `DM_WE`  in  1  store enable.
- `DM_RE`  in  1  load enable.
- `DM_Size`  in  2  access size: 00 word, 01 halfword, 10 byte, 11 illegal.
- `DM_Unsigned`  in  1  1 = zero-extend sub-word loads, 0 = sign-extend.
- `DM_RD`  out  32  load data, extended.
- `DM_AdEL`  out  1  load address error.
- `DM_AdES`  out  1  store address error.

## Operation
- Storage: array of 2^ADDR_WIDTH 32-bit words, indexed by `DM_Addr[ADDR_WIDTH+1:2]`.
- Byte order is little-endian: byte offset 0 is bits 7:0, and offset 2 halfword is bits 31:16.
- Address legality (combinational), `bad` when any of:
  - `DM_Addr >= 4*2^ADDR_WIDTH`;
  - word access with `DM_Addr[1:0]!=0`;
  - halfword access with `DM_Addr[0]!=0`;
  - `DM_Size==11`.
- `DM_AdEL = DM_RE & bad`. `DM_AdES = DM_WE & bad`.
- Store: when `DM_WE` is high and the address is not `bad`, at the rising edge write only the addressed lanes via per-byte enables.
  - Word: all four lanes from `DM_WD`.
  - Halfword: lanes {off+1, off} from `DM_WD[15:0]`.
  - Byte: lane `off` from `DM_WD[7:0]`.
  - Unaddressed lanes are unchanged.
- Illegal store: memory untouched; only `DM_AdES` is raised.
- Load: `DM_RD` is combinational from the currently stored word.
  - Select the addressed lane(s), then sign- or zero-extend per `DM_Unsigned`. A word load ignores `DM_Unsigned`.
  - `DM_RD = 0` when `DM_RE` is low or the load address is `bad`.
- `DM_WE` and `DM_RE` both high (not issued by the controller, but defined):
  - both error flags follow the rules above;
  - `DM_RD` shows pre-edge contents until the edge, then the new contents.

## Timing
- Reset:
  - `rst_n` low immediately clears every word to 0, independent of `clk`;
  - `DM_RD` is therefore 0 during and after reset;
  - `DM_AdEL` and `DM_AdES` stay purely combinational and remain valid during reset.
- A store coinciding with the edge at which `rst_n` is low is dropped. Memory is all-zero when `rst_n` deasserts.
- Store latency: 1 edge; visible on `DM_RD` in the cycle after the write edge (zero-delay combinational thereafter).
- Load latency: 0 cycles, combinational from `DM_Addr`/`DM_Size`/`DM_Unsigned`/`DM_RE`.
- Address boundaries:
  - last legal word `4*2^ADDR_WIDTH-4` is legal;
  - `4*2^ADDR_WIDTH` is illegal;
  - no wrap-around: high address bits are never truncated into a legal index.
- Back-to-back stores on consecutive edges to the same word merge correctly, because lanes are independent.

## Structure
- Package `dm_pkg`:
  - size encodings `DM_WORD`, `DM_HALF`, `DM_BYTE`, `DM_ILL`;
  - function computing the 4-bit byte-enable from size and offset.
- Sub-module `dm_load_ext`: purely combinational lane select plus sign/zero extend (word, size, offset, unsigned → 32-bit).
- `dm` top: array, reset clear, byte-enable write, legality check.

## Test plan
- Reset then word load of 0x0000_0010 → `DM_RD=0`, no flags.
- Store word 0x8765_4321 @0x10; then:
  - `lb` @0x11 signed → 0x0000_0043;
  - `lbu` @0x13 → 0x0000_0087;
  - `lb` @0x13 signed → 0xFFFF_FF87;
  - `lh` @0x12 → 0xFFFF_8765.
- After the above, `sb` 0xAA @0x12 then word load @0x10 → 0x87AA_4321. `sh` 0xBEEF @0x10 → 0x87AA_BEEF.
- Misalignment: word store @0x22 → `DM_AdES=1`, word @0x20 unchanged; `lh` @0x21 → `DM_AdEL=1`, `DM_RD=0`; `DM_Size=11` with `DM_RE` high → `DM_AdEL=1`.
- Range: store 0x1234_5678 @0xFFC → loads back; store @0x1000 → `DM_AdES=1`, word @0x000 unchanged (no wrap).
- Reset mid-operation: fill 0x10–0x1C, pull `rst_n` low between edges → all reads 0 immediately. A store held at the next edge while still in reset is not written.
